// File: rtl/data_memory_responder_pkg.sv
// data_memory_responder_pkg: shared format codes and fault indices
// for the data-memory responder and its load/store aligner.
package data_memory_responder_pkg;

  localparam logic [2:0] FMT_B  = 3'b000;
  localparam logic [2:0] FMT_H  = 3'b001;
  localparam logic [2:0] FMT_W  = 3'b010;
  localparam logic [2:0] FMT_BU = 3'b100;
  localparam logic [2:0] FMT_HU = 3'b101;

  localparam int FAULT_MISALIGNED = 0;
  localparam int FAULT_ACCESS     = 1;

  function automatic logic fmt_load_ok(
    input logic [2:0] f
  );
    return (f == FMT_B) || (f == FMT_H) ||
           (f == FMT_W) || (f == FMT_BU) ||
           (f == FMT_HU);
  endfunction

  function automatic logic fmt_store_ok(
    input logic [2:0] f
  );
    return (f == FMT_B) || (f == FMT_H) ||
           (f == FMT_W);
  endfunction

  function automatic logic fmt_misaligned(
    input logic [2:0] f,
    input logic [1:0] off
  );
    logic m;
    m = 1'b0;
    if (f == FMT_H || f == FMT_HU) m = off[0];
    if (f == FMT_W) m = |off;
    return m;
  endfunction

endpackage

// File: rtl/data_memory_responder_aligner.sv
// load_store_aligner: byte-enable mask, lane-replicated store
// data and sign/zero-extended load data for one access.
module load_store_aligner
  import data_memory_responder_pkg::*;
(
  input  logic [2:0]  format,
  input  logic [1:0]  offset,
  input  logic [31:0] raw_word,
  input  logic [31:0] store_data,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = raw_word[{offset, 3'b000} +: 8];
  assign lane_h = raw_word[{offset[1], 4'b0000} +: 16];

  // Per-format lane steering for both directions.
  always_comb begin
    byte_en    = 4'b0000;
    store_word = store_data;
    load_data  = '0;
    unique case (format)
      FMT_B: begin
        byte_en    = 4'b0001 << offset;
        store_word = {4{store_data[7:0]}};
        load_data  = {{24{lane_b[7]}}, lane_b};
      end
      FMT_H: begin
        byte_en    = 4'b0011 << offset;
        store_word = {2{store_data[15:0]}};
        load_data  = {{16{lane_h[15]}}, lane_h};
      end
      FMT_W: begin
        byte_en    = 4'b1111;
        load_data  = raw_word;
      end
      FMT_BU: load_data = {24'h0, lane_b};
      FMT_HU: load_data = {16'h0, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: word storage, decode and sticky faults.
// DMEM_CYCLE_COUNTER_EN adds a memory-mapped 64-bit cycle counter.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h1001_0000,
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] MMIO_BASE    = 32'hFFFF_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  format,
  output logic [31:0] read_data,
  output logic [1:0]  fault
);

  localparam int          IW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] rel;
  logic        in_range;
  logic [IW-1:0] idx;
  logic [1:0]  off;
  logic        access;
  logic        mis;
  logic        fmt_err;
  logic        acc_err;
  logic        rd_hit;
  logic        wr_hit;
  logic [3:0]  byte_en;
  logic [31:0] store_word;
  logic [31:0] load_data;

  assign rel      = address - BASE_ADDRESS;
  assign in_range = rel < SPAN;
  assign idx      = rel[IW+1:2];
  assign off      = address[1:0];
  assign access   = read_enable | write_enable;
  assign mis      = fmt_misaligned(format, off);
  assign fmt_err  = (read_enable & ~fmt_load_ok(format)) |
                    (write_enable & ~fmt_store_ok(format));
  assign rd_hit   = read_enable & fmt_load_ok(format) &
                    ~mis & in_range;
  assign wr_hit   = write_enable & fmt_store_ok(format) &
                    ~mis & in_range;

  load_store_aligner u_aligner (
    .format     (format),
    .offset     (off),
    .raw_word   (mem[idx]),
    .store_data (write_data),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_data)
  );

`ifdef DMEM_CYCLE_COUNTER_EN
  logic [63:0] counter;
  logic [31:0] mmio_rel;
  logic        mmio_hit;
  logic        mmio_ok;
  logic        rd_mmio;
  logic        wr_mmio;

  assign mmio_rel = address - MMIO_BASE;
  assign mmio_hit = mmio_rel < 32'd8;
  assign mmio_ok  = (format == FMT_W) & ~mis;
  assign rd_mmio  = read_enable & mmio_hit & mmio_ok;
  assign wr_mmio  = write_enable & mmio_hit & mmio_ok;
  assign acc_err  = mmio_hit ? (format != FMT_W)
                             : (~in_range | fmt_err);

  assign read_data =
    rd_mmio ? (mmio_rel[2] ? counter[63:32] : counter[31:0]) :
    rd_hit  ? load_data : '0;

  // Free-running counter; a store reloads one half, the low
  // half store suppresses carry into the high half.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter <= '0;
    end else if (wr_mmio && !mmio_rel[2]) begin
      counter <= {counter[63:32], write_data};
    end else if (wr_mmio) begin
      counter <= {write_data, counter[31:0] + 32'd1};
    end else begin
      counter <= counter + 64'd1;
    end
  end
`else
  assign acc_err   = ~in_range | fmt_err;
  assign read_data = rd_hit ? load_data : '0;
`endif

  // Byte-lane masked store; storage is never reset.
  always_ff @(posedge clock) begin
    if (wr_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem[idx][8*i +: 8] <= store_word[8*i +: 8];
        end
      end
    end
  end

  // Sticky fault flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fault <= 2'b00;
    end else if (access) begin
      fault[FAULT_MISALIGNED] <= fault[FAULT_MISALIGNED] | mis;
      fault[FAULT_ACCESS]     <= fault[FAULT_ACCESS] | acc_err;
    end
  end

endmodule
